row_loader: RTL and testbench
=============================

# row_loader

Upstream feeder for the row register file. Pops 64-bit words from the input-feature FIFO and writes them into the row register file one row at a time: 4 words in mode 0, 2 words in mode 1. After each complete row it pulses `fullRow` so the register file streams that row to the PE array. It holds off the next row until the previous one has drained, and it raises `threeRowready` once three rows of the current frame have been delivered.

## Interface
Parameters:
- `DW`, 64: FIFO / row word width.
- `RW`, 8: width of the rows-per-frame count.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle frame start; ignored unless idle.
- `mode` in 3: 0 = 4 words/row, 1 = 2 words/row, others behave as 0; sampled when `start` is accepted.
- `rowsPerFrame` in RW: rows in the frame; sampled when `start` is accepted.
- `fifoEmpty` in 1: FIFO empty flag.
- `fifoData` in DW: FIFO read data, valid the cycle after `fifoRd`.
- `fifoRd` out 1: FIFO pop, combinational.
- `writeEn` out 1: register-file write strobe, registered.
- `writeAddr` out 2: register-file word address, registered.
- `writeData` out DW: equals `fifoData` (pass-through).
- `fullRow` out 1: one-cycle row-complete pulse, registered.
- `threeRowready` out 1: level; high once 3 rows of the current frame are delivered.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle frame-complete pulse, registered.

## Operation
- Decoded row length: W = 2 if latched mode == 1, else W = 4.
- IDLE
  - On `start`: latch mode and `rowsPerFrame`, clear the row counter and `threeRowready`, enter FETCH.
  - If `rowsPerFrame` == 0: go to DONE instead.
- FETCH
  - `fifoRd` = !`fifoEmpty` && (issued < W). `issued` counts pops in this row.
  - The cycle after each pop: `writeEn`=1, `writeAddr` = index of the popped word (0..W-1). Words are written in pop order.
  - A FIFO that goes empty stalls popping only; no words are skipped or duplicated.
  - The cycle after the write to address W-1: `fullRow`=1 for one cycle, row counter +1, enter DRAIN.
- DRAIN
  - Lasts W-1 cycles after the `fullRow` cycle. The register file reads words 1..W-1 during this window, so no pops or writes occur.
  - At the end: if row counter == `rowsPerFrame`, go to DONE; else go to FETCH with `issued` = 0.
- DONE: `done`=1 for one cycle, then IDLE.
- `threeRowready`
  - Set the cycle after the third `fullRow` of the frame (counter reaches 3).
  - Stays high through DONE and IDLE.
  - Cleared only by an accepted `start` or by `rst`.
- Row counter is RW bits and saturates at the all-ones value; it never wraps.
- `start` while `busy`: ignored, with no effect on counters or latched mode.
- Mode changes while busy have no effect.

## Timing
- Reset values: `fifoRd`=0, `writeEn`=0, `writeAddr`=0, `fullRow`=0, `threeRowready`=0, `busy`=0, `done`=0; state IDLE; all counters 0. `writeData` follows `fifoData` regardless of reset.
- `rst` asserted mid-frame: at the next edge all of the above return to their reset values. Any pop already issued has its data dropped, with no `writeEn`.
- Latency for mode 0 with a never-empty FIFO, `start` high in cycle 0:
  - `fifoRd` high in cycles 1-4.
  - `writeEn` high in cycles 2-5 with addresses 0,1,2,3.
  - `fullRow` high in cycle 6; DRAIN in cycles 7-9.
  - Next row's `fifoRd` from cycle 10. Row period is 9 cycles.
- Mode 1 under the same conditions:
  - `fifoRd` high in cycles 1-2; `writeEn` high in cycles 2-3 with addresses 0,1.
  - `fullRow` high in cycle 4; DRAIN in cycle 5; next pop in cycle 6. Row period is 5 cycles.
- Last row: DONE (the `done` pulse) occurs the cycle after the final DRAIN cycle. `busy` drops the cycle after that.
- `fullRow` is never asserted in the same cycle as `writeEn`.
- A write never occurs in a cycle in which a word of the previous row is still unread.

## Test plan
- Mode 0, `rowsPerFrame`=3, FIFO words 0x1..0xC never empty -> writes 0x1-0x4 to addr 0-3; `fullRow` in cycles 6, 15, 24; `threeRowready` rises in cycle 25; `done` in cycle 28.
- Mode 1, `rowsPerFrame`=4, data 0xA0..0xA7 -> writes alternate addr 0,1; `fullRow` every 5 cycles (cycles 4, 9, 14, 19); exactly 8 pops; `done` once.
- Mode 0, `fifoEmpty` forced high for 3 cycles after the second pop -> no write during the stall; addr 2 and 3 receive the 3rd and 4th words; `fullRow` delayed by exactly 3 cycles.
- `rst` pulsed in cycle 3 of a mode-0 frame -> cycle 4 has all outputs 0 and `busy`=0; a later `start` restarts with addr 0 and a fresh row count.
- `rowsPerFrame`=0 -> no `fifoRd`; `done` the cycle after the IDLE exit; `threeRowready` stays 0. A second `start` issued while `busy` in another frame -> ignored (row count unchanged).
- Mode value 5 -> behaves exactly as mode 0 (4 writes per row, 9-cycle row period).

Source files
------------

// File: rtl/row_loader.sv
// Feeds the row register file from the input-feature FIFO one row at a time,
// pulsing fullRow per completed row and waiting for each row to drain.
module row_loader #(
  parameter int DW = 64,
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [RW-1:0] rowsPerFrame,
  input  logic          fifoEmpty,
  input  logic [DW-1:0] fifoData,
  output logic          fifoRd,
  output logic          writeEn,
  output logic [1:0]    writeAddr,
  output logic [DW-1:0] writeData,
  output logic          fullRow,
  output logic          threeRowready,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic          half_row;
  logic [RW-1:0] rows_q;
  logic [RW-1:0] row_cnt;
  logic [2:0]    issued;
  logic [1:0]    drain_cnt;
  logic [2:0]    row_len;
  logic [1:0]    last_addr;
  logic          row_written;

  assign row_len     = half_row ? 3'd2 : 3'd4;
  assign last_addr   = half_row ? 2'd1 : 2'd3;
  assign row_written = writeEn && (writeAddr == last_addr);

  assign fifoRd    = (state == S_FETCH) && !fifoEmpty && (issued < row_len);
  assign writeData = fifoData;
  assign busy      = (state != S_IDLE);

  // The DRAIN state also covers the fullRow cycle, so it spans W cycles in total.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      half_row      <= 1'b0;
      rows_q        <= '0;
      row_cnt       <= '0;
      issued        <= '0;
      drain_cnt     <= '0;
      writeEn       <= 1'b0;
      writeAddr     <= '0;
      fullRow       <= 1'b0;
      threeRowready <= 1'b0;
      done          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in this block override earlier defaults.
      writeEn <= fifoRd;
      fullRow <= 1'b0;
      done    <= 1'b0;

      if (fifoRd) begin
        writeAddr <= issued[1:0];
        issued    <= issued + 3'd1;
      end

      if (row_cnt == RW'(3)) threeRowready <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            half_row      <= (mode == 3'd1);
            rows_q        <= rowsPerFrame;
            row_cnt       <= '0;
            issued        <= '0;
            threeRowready <= 1'b0;
            if (rowsPerFrame == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (row_written) begin
            fullRow   <= 1'b1;
            drain_cnt <= '0;
            state     <= S_DRAIN;
            if (row_cnt != '1) row_cnt <= row_cnt + RW'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == last_addr) begin
            if (row_cnt == rows_q) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state  <= S_FETCH;
              issued <= '0;
            end
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_loader.sv
// Self-checking bench for row_loader: a timeline model derived from the row
// rules predicts every output per cycle for directed and randomized frames.
module tb_row_loader;
  localparam int DW   = 64;
  localparam int RW   = 8;
  localparam int MAXC = 1024;

  logic          clk;
  logic          rst;
  logic          start;
  logic [2:0]    mode;
  logic [RW-1:0] rowsPerFrame;
  logic          fifoEmpty;
  logic [DW-1:0] fifoData;
  logic          fifoRd;
  logic          writeEn;
  logic [1:0]    writeAddr;
  logic [DW-1:0] writeData;
  logic          fullRow;
  logic          threeRowready;
  logic          busy;
  logic          done;

  row_loader #(.DW(DW), .RW(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode         (mode),
    .rowsPerFrame (rowsPerFrame),
    .fifoEmpty    (fifoEmpty),
    .fifoData     (fifoData),
    .fifoRd       (fifoRd),
    .writeEn      (writeEn),
    .writeAddr    (writeAddr),
    .writeData    (writeData),
    .fullRow      (fullRow),
    .threeRowready(threeRowready),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit          exp_rd   [MAXC];
  bit          exp_we   [MAXC];
  bit          exp_full [MAXC];
  bit          exp_done [MAXC];
  bit          exp_busy [MAXC];
  bit          exp_three[MAXC];
  logic [1:0]  exp_addr [MAXC];
  logic [DW-1:0] exp_wd [MAXC];
  bit          empty_pat[MAXC];
  bit          prev_three = 1'b0;
  int          last_cycle;
  int          done_cycle;

  task automatic check(input string tag, input int cyc, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic prepare_empty(input int kind);
    for (int i = 0; i < MAXC; i++)
      empty_pat[i] = (kind == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  // Timeline model: each row pops the first W non-empty FETCH cycles, writes
  // one cycle later, pulses fullRow two cycles after its last pop, then waits
  // W-1 drain cycles; done follows the last drain cycle.
  task automatic build_model(input int mode_v, input int rows, input int rst_cycle,
                             input logic [DW-1:0] base);
    int w, t, c, k, npop, delivered, last_pop, f, three_from;
    for (int i = 0; i < MAXC; i++) begin
      exp_rd[i] = 0; exp_we[i] = 0; exp_full[i] = 0; exp_done[i] = 0;
      exp_busy[i] = 0; exp_three[i] = 0; exp_addr[i] = 'x; exp_wd[i] = 'x;
    end
    w = (mode_v == 1) ? 2 : 4;
    three_from = -1;
    if (rows == 0) begin
      done_cycle = 1;
    end else begin
      t = 1; npop = 0; delivered = 0; last_pop = 0;
      for (int r = 0; r < rows; r++) begin
        k = 0; c = t;
        while (k < w && c < MAXC - 16) begin
          if (!empty_pat[c]) begin
            exp_rd[c] = 1;
            exp_we[c + 1] = 1;
            exp_addr[c + 1] = 2'(k);
            exp_wd[c + 1] = base + DW'(npop);
            npop++; k++; last_pop = c;
          end
          c++;
        end
        f = last_pop + 2;
        exp_full[f] = 1;
        delivered++;
        if (delivered == 3) three_from = f + 1;
        t = f + w;
      end
      done_cycle = t;
    end
    exp_done[done_cycle] = 1;
    for (int i = 1; i <= done_cycle; i++) exp_busy[i] = 1;
    last_cycle = done_cycle + 1;
    exp_three[0] = prev_three;
    for (int i = 1; i <= last_cycle; i++) exp_three[i] = (three_from > 0) && (i >= three_from);
    if (rst_cycle > 0) begin
      for (int i = rst_cycle + 1; i < MAXC; i++) begin
        exp_rd[i] = 0; exp_we[i] = 0; exp_full[i] = 0; exp_done[i] = 0;
        exp_busy[i] = 0; exp_three[i] = 0;
      end
      last_cycle = rst_cycle + 1;
      prev_three = 1'b0;
    end else begin
      prev_three = exp_three[last_cycle];
    end
  endtask

  // Entered just after a rising edge; cycle 0 carries start.
  task automatic run_frame(input int mode_v, input int rows, input int rst_cycle,
                           input logic [DW-1:0] base, input int spurious);
    int pop_idx;
    bit rd_seen;
    pop_idx = 0;
    build_model(mode_v, rows, rst_cycle, base);
    for (int c = 0; c <= last_cycle; c++) begin
      start        = (c == 0) || (c == spurious);
      mode         = (c == 0) ? 3'(mode_v) : 3'($urandom_range(0, 7));
      rowsPerFrame = (c == 0) ? RW'(rows) : RW'($urandom_range(0, 255));
      rst          = (rst_cycle > 0) && (c == rst_cycle);
      fifoEmpty    = empty_pat[c];
      @(negedge clk);
      check("fifoRd", c, DW'(fifoRd), DW'(exp_rd[c]));
      check("writeEn", c, DW'(writeEn), DW'(exp_we[c]));
      if (exp_we[c]) begin
        check("writeAddr", c, DW'(writeAddr), DW'(exp_addr[c]));
        check("writeData", c, writeData, exp_wd[c]);
      end
      check("fullRow", c, DW'(fullRow), DW'(exp_full[c]));
      check("done", c, DW'(done), DW'(exp_done[c]));
      check("busy", c, DW'(busy), DW'(exp_busy[c]));
      check("threeRowready", c, DW'(threeRowready), DW'(exp_three[c]));
      if (rst_cycle > 0 && c == rst_cycle + 1)
        check("writeAddr_rst", c, DW'(writeAddr), '0);
      rd_seen = fifoRd;
      @(posedge clk);
      #1;
      if (rd_seen) begin
        fifoData = base + DW'(pop_idx);
        pop_idx++;
      end
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    int m, r, sp;
    rst = 1'b1; start = 1'b0; mode = '0; rowsPerFrame = '0;
    fifoEmpty = 1'b1; fifoData = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_fifoRd", 0, DW'(fifoRd), '0);
    check("rst_writeEn", 0, DW'(writeEn), '0);
    check("rst_writeAddr", 0, DW'(writeAddr), '0);
    check("rst_fullRow", 0, DW'(fullRow), '0);
    check("rst_three", 0, DW'(threeRowready), '0);
    check("rst_busy", 0, DW'(busy), '0);
    check("rst_done", 0, DW'(done), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Mode 0, three rows, never empty: fullRow 6/15/24, done 28.
    prepare_empty(0);
    run_frame(0, 3, 0, 64'h1, -1);

    // Mode 1, four rows, with a start issued while busy.
    prepare_empty(0);
    run_frame(1, 4, 0, 64'hA0, 7);

    // Mode 0 with a 3-cycle empty stall after the second pop.
    prepare_empty(0);
    empty_pat[3] = 1; empty_pat[4] = 1; empty_pat[5] = 1;
    run_frame(0, 1, 0, 64'h100, -1);

    // Reset mid-frame, then a fresh frame.
    prepare_empty(0);
    run_frame(0, 3, 3, 64'h200, -1);
    prepare_empty(0);
    run_frame(0, 2, 0, 64'h300, -1);

    // Zero-row frame.
    prepare_empty(0);
    run_frame(0, 0, 0, 64'h400, -1);

    // Mode 5 behaves as mode 0.
    prepare_empty(0);
    run_frame(5, 2, 0, 64'h500, -1);

    // Randomized frames with random FIFO empties and stray starts.
    for (int n = 0; n < 8; n++) begin
      m = $urandom_range(0, 7);
      r = $urandom_range(1, 5);
      prepare_empty(1);
      sp = $urandom_range(1, 20);
      run_frame(m, r, 0, DW'(32'h1000 * (n + 1)), sp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
